usb_data_buffer: RTL and testbench

- 64-byte circular byte FIFO shared by the USB endpoint datapath.
- RX direction: the USB RX block pushes single bytes, and the AHB-Lite slave pops 1-4 bytes per access.
- TX direction: the AHB-Lite slave pushes 1-4 bytes per access, and the USB TX block pops single bytes.
- Reports current occupancy to the protocol controller.

---
 rtl/data_buffer_pkg.sv | 29 ++
 rtl/usb_data_buffer_if.sv | 47 ++++
 rtl/data_buffer_regfile.sv | 33 +++
 rtl/usb_data_buffer.sv | 122 ++++++++++++
 tb/tb_usb_data_buffer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_buffer_pkg.sv
// ---------------------------------------------------------------------------
// data_buffer_pkg
// Shared constants and types for the USB endpoint byte FIFO.
//   DEPTH       : buffer capacity in bytes (power of 2)
//   OCC_W       : occupancy counter width, holds 0..DEPTH
//   PTR_W       : read/write pointer width, wraps DEPTH-1 -> 0
//   byte_t      : one stored byte
//   xfer_size_e : AHB access size encoding (data_size port)
// ---------------------------------------------------------------------------
package data_buffer_pkg;
  localparam int DEPTH = 64;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int LANES = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_3B = 2'd2,
    SIZE_4B = 2'd3
  } xfer_size_e;

  // Number of bytes moved by one AHB access of the given size (1..4).
  function automatic logic [2:0] xfer_bytes(xfer_size_e size);
    return {1'b0, size} + 3'd1;
  endfunction
endpackage

// File: rtl/usb_data_buffer_if.sv
// ---------------------------------------------------------------------------
// usb_data_buffer_if
// Request/response bundle between the USB RX/TX blocks, the AHB-Lite slave,
// the protocol controller and the byte FIFO.
//   master : drives strobes and write data, observes occupancy and read data
//   slave  : the FIFO itself
// Optional macro DATA_BUFFER_ERR_EN adds the sticky buffer_error flag.
// ---------------------------------------------------------------------------
interface usb_data_buffer_if;
  import data_buffer_pkg::*;

  logic             clear;
  logic             store_rx_packet_data;
  byte_t            rx_packet_data;
  logic             get_rx_data;
  logic [1:0]       data_size;
  logic [31:0]      tx_data;
  logic             store_tx_data;
  logic             get_tx_packet_data;
  logic             buffer_reserved;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [31:0]      rx_data;
  byte_t            tx_packet_data;
`ifdef DATA_BUFFER_ERR_EN
  logic             buffer_error;
`endif

  modport master (
`ifdef DATA_BUFFER_ERR_EN
    input  buffer_error,
`endif
    output clear, store_rx_packet_data, rx_packet_data, get_rx_data,
    output data_size, tx_data, store_tx_data, get_tx_packet_data,
    output buffer_reserved,
    input  buffer_occupancy, rx_data, tx_packet_data
  );

  modport slave (
`ifdef DATA_BUFFER_ERR_EN
    output buffer_error,
`endif
    input  clear, store_rx_packet_data, rx_packet_data, get_rx_data,
    input  data_size, tx_data, store_tx_data, get_tx_packet_data,
    input  buffer_reserved,
    output buffer_occupancy, rx_data, tx_packet_data
  );
endinterface

// File: rtl/data_buffer_regfile.sv
// ---------------------------------------------------------------------------
// data_buffer_regfile
// DEPTH x 8 register array with LANES write lanes and LANES combinational
// read lanes. Contents are not reset.
//   clk      : system clock
//   i_we     : per-lane write enable
//   i_waddr  : per-lane write address (lanes must target distinct entries)
//   i_wdata  : per-lane write byte
//   i_raddr  : per-lane read address
//   o_rdata  : per-lane read byte (combinational)
// ---------------------------------------------------------------------------
module data_buffer_regfile
  import data_buffer_pkg::*;
(
  input  logic             clk,
  input  logic [LANES-1:0] i_we,
  input  logic [PTR_W-1:0] i_waddr [LANES],
  input  byte_t            i_wdata [LANES],
  input  logic [PTR_W-1:0] i_raddr [LANES],
  output byte_t            o_rdata [LANES]
);
  byte_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_we[l]) r_mem[i_waddr[l]] <= i_wdata[l];
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
    assign o_rdata[gi] = r_mem[i_raddr[gi]];
  end
endmodule

// File: rtl/usb_data_buffer.sv
// ---------------------------------------------------------------------------
// usb_data_buffer
// 64-byte circular byte FIFO between the USB RX/TX blocks and the AHB-Lite
// slave. Pushes of 1..4 bytes are all-or-nothing; pops are clamped to the
// bytes available, with missing bytes reading as zero.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : usb_data_buffer_if.slave (strobes, data, occupancy, read data)
// Optional macro DATA_BUFFER_ERR_EN: sticky buffer_error on a dropped push
// or a clamped pop.
// ---------------------------------------------------------------------------
module usb_data_buffer
  import data_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  usb_data_buffer_if.slave bus
);
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [31:0]      r_rx_data;
  byte_t            r_tx_byte;

  logic [2:0]       w_size_bytes;
  logic [2:0]       w_push_cnt;
  logic [2:0]       w_pop_req;
  logic [2:0]       w_pop_cnt;
  logic             w_push_ok;
  logic [LANES-1:0] w_we;
  logic [PTR_W-1:0] w_waddr [LANES];
  byte_t            w_wdata [LANES];
  logic [PTR_W-1:0] w_raddr [LANES];
  byte_t            w_rdata [LANES];
  logic [31:0]      w_rx_word;
  logic             w_unused_reserved;

  // Ownership status is informational only.
  assign w_unused_reserved = bus.buffer_reserved;

  assign w_size_bytes = xfer_bytes(xfer_size_e'(bus.data_size));

  // AHB side wins both arbitrations; all checks use pre-edge occupancy.
  always_comb begin
    w_push_cnt = 3'd0;
    if (bus.store_tx_data)             w_push_cnt = w_size_bytes;
    else if (bus.store_rx_packet_data) w_push_cnt = 3'd1;

    w_pop_req = 3'd0;
    if (bus.get_rx_data)             w_pop_req = w_size_bytes;
    else if (bus.get_tx_packet_data) w_pop_req = 3'd1;

    w_push_ok = (w_push_cnt != 3'd0) &&
                ((OCC_W+1)'(r_occ) + (OCC_W+1)'(w_push_cnt) <= (OCC_W+1)'(DEPTH));

    // When clamping, occupancy is below 4 so its low bits are the count.
    w_pop_cnt = (OCC_W'(w_pop_req) > r_occ) ? r_occ[2:0] : w_pop_req;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_we[gi]    = w_push_ok && (3'(gi) < w_push_cnt);
    assign w_waddr[gi] = r_wr_ptr + PTR_W'(gi);
    assign w_wdata[gi] = bus.store_tx_data ? bus.tx_data[8*gi +: 8] : bus.rx_packet_data;
    assign w_raddr[gi] = r_rd_ptr + PTR_W'(gi);
    // Bytes beyond the clamped count (short buffer or small access) are zero.
    assign w_rx_word[8*gi +: 8] = (3'(gi) < w_pop_cnt) ? w_rdata[gi] : 8'h00;
  end

  data_buffer_regfile u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_occ     <= '0;
      r_rx_data <= '0;
      r_tx_byte <= '0;
    end else if (bus.clear) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_occ     <= '0;
      r_rx_data <= '0;
      r_tx_byte <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_cnt);
      r_occ    <= r_occ + (w_push_ok ? OCC_W'(w_push_cnt) : '0) - OCC_W'(w_pop_cnt);
      if (bus.get_rx_data)
        r_rx_data <= w_rx_word;
      else if (bus.get_tx_packet_data)
        r_tx_byte <= (r_occ != '0) ? w_rdata[0] : 8'h00;
    end
  end

  assign bus.buffer_occupancy = r_occ;
  assign bus.rx_data          = r_rx_data;
  assign bus.tx_packet_data   = r_tx_byte;

`ifdef DATA_BUFFER_ERR_EN
  logic r_err;
  logic w_overflow;
  logic w_underflow;

  assign w_overflow  = (w_push_cnt != 3'd0) && !w_push_ok;
  assign w_underflow = OCC_W'(w_pop_req) > r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (bus.clear) r_err <= 1'b0;
    else                r_err <= r_err | w_overflow | w_underflow;
  end

  assign bus.buffer_error = r_err;
`endif
endmodule

// File: tb/tb_usb_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_data_buffer
// Byte-queue reference model with expected-result scoreboard queues for the
// usb_data_buffer FIFO. Define DATA_BUFFER_ERR_EN to also check buffer_error.
// ---------------------------------------------------------------------------
module tb_usb_data_buffer;
  import data_buffer_pkg::*;

  logic clk;
  logic rst;
  usb_data_buffer_if bus();

  usb_data_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  byte_t       model_q[$];
  logic [31:0] exp_rx_q[$];
  byte_t       exp_tx_q[$];
  bit          model_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    bus.clear                = 1'b0;
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.data_size            = 2'd0;
    bus.tx_data              = 32'h0;
    bus.store_tx_data        = 1'b0;
    bus.get_tx_packet_data   = 1'b0;
    bus.buffer_reserved      = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rx_q.delete();
    exp_tx_q.delete();
    model_err = 1'b0;
  endtask

  // One request cycle: update the model, drive, clock, compare.
  task automatic op(input bit s_rx, input byte_t rxb, input bit g_rx,
                    input logic [1:0] sz, input logic [31:0] txd,
                    input bit s_tx, input bit g_tx);
    int p, qreq, q, occ_pre;
    logic [31:0] word;
    byte_t tb_byte;
    occ_pre = model_q.size();
    p    = s_tx ? int'(sz) + 1 : (s_rx ? 1 : 0);
    qreq = g_rx ? int'(sz) + 1 : (g_tx ? 1 : 0);
    q    = (qreq > occ_pre) ? occ_pre : qreq;
    if (p != 0 && occ_pre + p > DEPTH) model_err = 1'b1;
    if (qreq > occ_pre) model_err = 1'b1;
    if (g_rx) begin
      word = 32'h0;
      for (int k = 0; k < q; k++) word[8*k +: 8] = model_q[k];
      exp_rx_q.push_back(word);
    end else if (g_tx) begin
      exp_tx_q.push_back((q != 0) ? model_q[0] : 8'h00);
    end
    for (int k = 0; k < q; k++) void'(model_q.pop_front());
    if (p != 0 && occ_pre + p <= DEPTH) begin
      for (int k = 0; k < p; k++) begin
        tb_byte = s_tx ? txd[8*k +: 8] : rxb;
        model_q.push_back(tb_byte);
      end
    end

    bus.store_rx_packet_data = s_rx;
    bus.rx_packet_data       = rxb;
    bus.get_rx_data          = g_rx;
    bus.data_size            = sz;
    bus.tx_data              = txd;
    bus.store_tx_data        = s_tx;
    bus.get_tx_packet_data   = g_tx;
    @(posedge clk);
    #1;
    idle_inputs();

    if (g_rx)      check("rx_data", bus.rx_data, exp_rx_q.pop_front());
    else if (g_tx) check("tx_packet_data", {24'h0, bus.tx_packet_data}, {24'h0, exp_tx_q.pop_front()});
    check("occupancy", 32'(bus.buffer_occupancy), 32'(model_q.size()));
`ifdef DATA_BUFFER_ERR_EN
    check("buffer_error", {31'h0, bus.buffer_error}, {31'h0, model_err});
`endif
  endtask

  task automatic rx_push(input byte_t b);
    op(1'b1, b, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic rx_pop(input logic [1:0] sz);
    op(1'b0, 8'h00, 1'b1, sz, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic tx_push(input logic [1:0] sz, input logic [31:0] d);
    op(1'b0, 8'h00, 1'b0, sz, d, 1'b1, 1'b0);
  endtask
  task automatic tx_pop();
    op(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("rst_rx_data", bus.rx_data, 32'd0);
    check("rst_tx_data", {24'h0, bus.tx_packet_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // RX bytes assembled little-endian by a 4-byte AHB read.
    rx_push(8'hFF); rx_push(8'hC9); rx_push(8'h9A); rx_push(8'h3B);
    rx_pop(2'd3);
    check("plan_rx_word", bus.rx_data, 32'h3B9AC9FF);

    // 2-byte AHB write drained by USB TX.
    do_reset();
    tx_push(2'd1, 32'h00002B67);
    tx_pop();
    check("plan_tx_b0", {24'h0, bus.tx_packet_data}, 32'h67);
    tx_pop();
    check("plan_tx_b1", {24'h0, bus.tx_packet_data}, 32'h2B);

    // Fill, overflow, drain; twice so pointers wrap from a nonzero base.
    do_reset();
    rx_push(8'h11); rx_pop(2'd0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) rx_push(byte_t'($urandom_range(0, 255)));
      rx_push(8'hEE);
      for (int i = 0; i < DEPTH / 4; i++) rx_pop(2'd3);
    end

    // Short buffer: 4-byte read with only 2 bytes present.
    do_reset();
    rx_push(8'hB0); rx_push(8'hB1);
    rx_pop(2'd3);
    check("plan_short_read", bus.rx_data, 32'h0000B1B0);
    tx_pop();  // pop while empty returns 0

    // Near-full push rejection, then simultaneous push and pop.
    do_reset();
    for (int i = 0; i < DEPTH - 2; i++) rx_push(byte_t'(i + 8'h40));
    tx_push(2'd3, 32'hA1A2A3A4);
    tx_push(2'd1, 32'h0000C2C1);   // exactly fits
    op(1'b1, 8'h5A, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);  // full: push dropped, pop taken
    op(1'b1, 8'h5B, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    op(1'b1, 8'h77, 1'b1, 2'd2, 32'hD3D2D1D0, 1'b1, 1'b1);  // AHB wins both sides
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      op(1'b0, 8'h00, 1'b1, 2'(i % 4), w, 1'b1, 1'b0);
    end

    // Synchronous clear overrides simultaneous requests.
    do_reset();
    for (int i = 0; i < 10; i++) rx_push(byte_t'(8'hA0 + i));
    rx_pop(2'd1);
    tx_pop();
    bus.clear = 1'b1;
    bus.store_rx_packet_data = 1'b1;
    bus.get_rx_data = 1'b1;
    bus.data_size = 2'd3;
    @(posedge clk);
    #1;
    idle_inputs();
    model_reset();
    check("clear_occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("clear_rx_data", bus.rx_data, 32'd0);
    check("clear_tx_data", {24'h0, bus.tx_packet_data}, 32'd0);
    rx_push(8'h21); rx_push(8'h22);
    rx_pop(2'd0);

    // Asynchronous reset in mid-cycle, no clock edge involved.
    for (int i = 0; i < 5; i++) rx_push(byte_t'(8'h30 + i));
    tx_pop();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("async_rst_tx_data", {24'h0, bus.tx_packet_data}, 32'd0);
    check("async_rst_rx_data", bus.rx_data, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_push(8'h99);
    tx_pop();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
